// File: rtl/seq_player.sv
// seq_player: records a short sequence of colours and plays it back.
// In playback, each step is lit for ON_CYCLES cycles and then dark for
// GAP_CYCLES cycles.
//
// Parameters
//   DEPTH       maximum number of stored steps (power of two, 2..64)
//   ON_CYCLES   number of cycles each step is lit (>= 1)
//   GAP_CYCLES  number of dark, silent cycles after each step (>= 1)
//
// Ports
//   CLK, RST     clock and synchronous active-high reset
//   clear        empty the stored sequence (IDLE only)
//   append       store color_in at index len (IDLE only, ignored when full)
//   color_in     colour to append: 0=red 1=green 2=blue 3=yellow
//   start        play steps 0..len-1 (IDLE only; lowest priority)
//   rd_idx       index for the check read
//   rd_color     combinational read of the stored colour at rd_idx
//   len, full    number of stored steps; full when len == DEPTH
//   busy         high while playback runs (ON or GAP)
//   done         one-cycle pulse on the first IDLE cycle after playback
//   color_valid  a step is lit; color_out is its colour (0 otherwise)
//   note         tone select: colour+1 while lit, 0 when silent
module seq_player #(
    parameter int DEPTH      = 32,
    parameter int ON_CYCLES  = 50_000_000,
    parameter int GAP_CYCLES = 25_000_000
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       clear,
    input  logic                       append,
    input  logic [1:0]                 color_in,
    input  logic                       start,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [1:0]                 rd_color,
    output logic [$clog2(DEPTH):0]     len,
    output logic                       full,
    output logic                       busy,
    output logic                       done,
    output logic                       color_valid,
    output logic [1:0]                 color_out,
    output logic [2:0]                 note
);

    localparam int IW   = $clog2(DEPTH);
    localparam int LW   = IW + 1;
    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    state_t          state, state_nxt;
    logic [1:0]      mem [DEPTH];
    logic [TW-1:0]   timer;
    logic [IW-1:0]   idx;
    logic [LW-1:0]   play_len;
    logic [LW-1:0]   idx_plus1;

    logic idle, do_clear, do_append, do_start, start_play, start_empty;
    logic last_step;

    // Command decode: only honoured in IDLE, priority clear > append > start.
    assign idle        = (state == IDLE);
    assign do_clear    = idle && clear;
    assign do_append   = idle && !clear && append && !full;
    assign do_start    = idle && !clear && !append && start;
    assign start_play  = do_start && (len != '0);
    assign start_empty = do_start && (len == '0);

    assign idx_plus1   = LW'(idx) + LW'(1);
    assign last_step   = !(idx_plus1 < play_len);

    assign full        = (len == LW'(DEPTH));
    assign rd_color    = mem[rd_idx];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_play) state_nxt = ON;
            ON:   if (timer == ON_LAST) state_nxt = GAP;
            GAP:  if (timer == GAP_LAST) state_nxt = last_step ? IDLE : ON;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy        = 1'b0;
        color_valid = 1'b0;
        color_out   = 2'd0;
        note        = 3'd0;
        case (state)
            ON: begin
                busy        = 1'b1;
                color_valid = 1'b1;
                color_out   = mem[idx];
                note        = {1'b0, mem[idx]} + 3'd1;
            end
            GAP:     busy = 1'b1;
            default: ;
        endcase
    end

    // Datapath: timer, step index, length and done pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            timer    <= '0;
            idx      <= '0;
            play_len <= '0;
            len      <= '0;
            done     <= 1'b0;
        end else begin
            done <= start_empty || (state == GAP && state_nxt == IDLE);

            // Timer restarts on every state change, so it never wraps.
            if (idle || state != state_nxt) timer <= '0;
            else                            timer <= timer + TW'(1);

            if (start_play) begin
                idx      <= '0;
                play_len <= len;
            end else if (state == GAP && state_nxt == ON) begin
                idx <= idx + IW'(1);
            end

            if (do_clear)       len <= '0;
            else if (do_append) len <= len + LW'(1);
        end
    end

    // Sequence storage; contents after clear or reset are don't-care.
    always_ff @(posedge CLK) begin
        if (!RST && do_append) mem[len[IW-1:0]] <= color_in;
    end

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player (DEPTH=4, ON_CYCLES=4, GAP_CYCLES=2).
// The stimulus side keeps a plain model of the stored sequence; every
// accepted start pushes the expected lit cycles and the done pulse, each
// stamped with its cycle, and a monitor pops them as the DUT shows them.
module tb_seq_player;

    localparam int DEPTH = 4;
    localparam int ONC   = 4;
    localparam int GAPC  = 2;
    localparam int STEP  = ONC + GAPC;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       clear = 1'b0, append = 1'b0, start = 1'b0;
    logic [1:0] color_in = 2'd0;
    logic [1:0] rd_idx = 2'd0;
    logic [1:0] rd_color;
    logic [2:0] len;
    logic       full, busy, done, color_valid;
    logic [1:0] color_out;
    logic [2:0] note;

    seq_player #(.DEPTH(DEPTH), .ON_CYCLES(ONC), .GAP_CYCLES(GAPC)) dut (
        .CLK(CLK), .RST(RST), .clear(clear), .append(append),
        .color_in(color_in), .start(start), .rd_idx(rd_idx),
        .rd_color(rd_color), .len(len), .full(full), .busy(busy),
        .done(done), .color_valid(color_valid), .color_out(color_out),
        .note(note)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_done;
        int color;
        int note;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Model state
    int  m_len = 0;
    int  m_mem[DEPTH];
    int  busy_lo = 1;
    int  busy_hi = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Monitor
    always @(negedge CLK) begin
        if (!RST) begin
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (!color_valid) chk("dark_out", int'({note, color_out}), 0);
            if (color_valid || done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got valid=%0d done=%0d expected none (cycle %0d)",
                             color_valid, done, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_done", int'(done), int'(e.is_done));
                    chk("ev_valid", int'(color_valid), int'(!e.is_done));
                    if (!e.is_done) begin
                        chk("ev_color", int'(color_out), e.color);
                        chk("ev_note", int'(note), e.note);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One input cycle; the model applies the IDLE command rules.
    task automatic drive(input bit cl, input bit ap, input logic [1:0] col, input bit st);
        int sc;
        bit m_idle;
        sc = cyc;
        m_idle = !(sc >= busy_lo && sc <= busy_hi);
        if (m_idle) begin
            if (cl) m_len = 0;
            else if (ap) begin
                if (m_len < DEPTH) begin
                    m_mem[m_len] = int'(col);
                    m_len++;
                end
            end else if (st) begin
                for (int k = 0; k < m_len; k++)
                    for (int j = 0; j < ONC; j++)
                        exp_q.push_back('{sc + 1 + k*STEP + j, 1'b0, m_mem[k], m_mem[k] + 1});
                exp_q.push_back('{sc + 1 + m_len*STEP, 1'b1, 0, 0});
                busy_lo = sc + 1;
                busy_hi = sc + m_len*STEP;
            end
        end
        clear = cl; append = ap; color_in = col; start = st;
        tick();
        clear = 0; append = 0; start = 0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc <= busy_hi + 1 && guard < 200) begin
            tick();
            guard++;
        end
        tick();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic chk_store(input string nm);
        chk({nm, "_len"}, int'(len), m_len);
        chk({nm, "_full"}, int'(full), int'(m_len == DEPTH));
        for (int i = 0; i < m_len; i++) begin
            rd_idx = 2'(i);
            #1;
            chk({nm, "_rd"}, int'(rd_color), m_mem[i]);
        end
    endtask

    task automatic abort_reset();
        RST = 1;
        busy_hi = cyc;
        exp_q.delete();
        m_len = 0;
        tick();
        RST = 0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_note", int'(note), 0);
        chk("rst_len", int'(len), 0);
    endtask

    initial begin
        int target, sc, n;
        logic [1:0] c;

        // Reset state
        tick(); tick();
        RST = 0;
        chk("rst_len0", int'(len), 0);
        chk("rst_full0", int'(full), 0);
        chk("rst_busy0", int'(busy), 0);
        chk("rst_done0", int'(done), 0);
        chk("rst_cv0", int'(color_valid), 0);
        chk("rst_co0", int'(color_out), 0);
        chk("rst_note0", int'(note), 0);

        // Fixed sequence 2,0,3 then play
        drive(0, 1, 2'd2, 0);
        drive(0, 1, 2'd0, 0);
        drive(0, 1, 2'd3, 0);
        chk_store("seq203");
        drive(0, 0, 2'd0, 1);
        wait_idle();

        // Start with an empty sequence
        drive(1, 0, 2'd0, 0);
        drive(0, 0, 2'd0, 1);
        wait_idle();

        // Fill past DEPTH; fifth append ignored
        for (int i = 0; i < 5; i++) drive(0, 1, 2'($urandom_range(0, 3)), 0);
        chk_store("full");

        // clear and append together: clear wins
        drive(1, 1, 2'd1, 0);
        chk("clr_app_len", int'(len), 0);

        // append and start together: append wins, no playback
        drive(0, 1, 2'd1, 1);
        chk("app_start_len", int'(len), 1);
        repeat (4) tick();
        drive(0, 1, 2'd3, 0);
        drive(0, 1, 2'd2, 0);
        drive(0, 0, 2'd0, 1);
        tick(); tick();
        drive(1, 0, 2'd0, 0);     // ignored while busy
        drive(0, 1, 2'd0, 0);     // ignored while busy
        drive(0, 0, 2'd0, 1);     // ignored while busy
        chk_store("busy_ign");
        wait_idle();
        chk_store("after_busy");

        // Reset during ON of step 1
        sc = cyc;
        drive(0, 0, 2'd0, 1);
        target = sc + 1 + STEP + 1;
        while (cyc < target) tick();
        abort_reset();
        repeat (30) tick();
        chk("abort_drained", exp_q.size(), 0);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) drive(1, 0, 2'd0, 0);
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) begin
                c = 2'($urandom_range(0, 3));
                drive(0, 1, c, 0);
            end
            chk_store("rnd");
            drive(0, 0, 2'd0, 1);
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
